// File: rtl/seg7_pkg.sv
// Shared glyph constants and the nibble-to-segment decode used by the scan driver.
// Segment order is {a,b,c,d,e,f,g}, active-low.
`timescale 1ns/1ps
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001101;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  // Segment pattern plus decimal point for one digit slot, both active-low.
  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
  } seg7_drive_t;

  function automatic logic [6:0] seg7_decode(input logic [3:0] nibble, input logic hex_mode);
    logic [6:0] v_seg;
    case (nibble)
      4'h0:    v_seg = SEG_0;
      4'h1:    v_seg = SEG_1;
      4'h2:    v_seg = SEG_2;
      4'h3:    v_seg = SEG_3;
      4'h4:    v_seg = SEG_4;
      4'h5:    v_seg = SEG_5;
      4'h6:    v_seg = SEG_6;
      4'h7:    v_seg = SEG_7;
      4'h8:    v_seg = SEG_8;
      4'h9:    v_seg = SEG_9;
      4'hA:    v_seg = SEG_A;
      4'hB:    v_seg = SEG_B;
      4'hC:    v_seg = SEG_C;
      4'hD:    v_seg = SEG_D;
      4'hE:    v_seg = SEG_E;
      default: v_seg = SEG_F;
    endcase
    if (!hex_mode && nibble > 4'h9) begin
      v_seg = SEG_DASH;
    end
    return v_seg;
  endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Combinational glyph lookup for the currently scanned nibble.
`timescale 1ns/1ps
module seg7_glyph
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_hex_mode,
  output logic [6:0] o_seg
);

  assign o_seg = seg7_decode(i_nibble, i_hex_mode);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver: prescaled digit scan, per-frame input
// snapshot, leading-zero blanking, blink and registered active-low pin outputs.
`timescale 1ns/1ps
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLINK_FRAMES = 64,
  parameter int HEX_MODE     = 1,
  parameter int LZ_BLANK     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [4*N_DIGITS-1:0] digits,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blink_mask,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic [N_DIGITS-1:0]   an_out,
  output logic                  frame_done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic          HEX_BIT    = (HEX_MODE != 0);

  logic [PW-1:0]         r_presc;
  logic [IW-1:0]         r_idx;
  logic [BW-1:0]         r_blink_cnt;
  logic                  r_phase;
  logic [4*N_DIGITS-1:0] r_dig_snap;
  logic [N_DIGITS-1:0]   r_dp_snap;
  logic [6:0]            r_seg;
  logic                  r_dp;
  logic [N_DIGITS-1:0]   r_an;
  logic                  r_frame_done;

  logic                  w_tick;
  logic                  w_wrap;
  logic [N_DIGITS-1:0]   w_lz;
  logic [3:0]            w_nib;
  logic                  w_sel_lz;
  logic                  w_sel_blink;
  logic                  w_sel_dp;
  logic [N_DIGITS-1:0]   w_an_nxt;
  logic [6:0]            w_glyph;
  seg7_drive_t           w_drv_nxt;

  assign w_tick = (r_presc == PRESC_LAST);
  assign w_wrap = w_tick && (r_idx == IDX_LAST);

  // Scan timing: prescaler, digit index and blink phase run regardless of enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc     <= '0;
      r_idx       <= '0;
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) begin
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end
      if (w_wrap) begin
        if (r_blink_cnt == BLINK_LAST) begin
          r_blink_cnt <= '0;
          r_phase     <= ~r_phase;
        end else begin
          r_blink_cnt <= r_blink_cnt + 1'b1;
        end
      end
    end
  end

  // Inputs are captured only at the frame wrap so a frame never mixes old and new values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dig_snap   <= '0;
      r_dp_snap    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_wrap) begin
        r_dig_snap <= digits;
        r_dp_snap  <= dp_in;
      end
      r_frame_done <= w_wrap;
    end
  end

  // Walk from the most significant digit down; a digit is blank while every digit at or above it is zero.
  always_comb begin : lz_mask
    logic v_run;
    v_run = 1'b1;
    w_lz  = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      v_run = v_run & (r_dig_snap[4*i +: 4] == 4'h0);
      if (LZ_BLANK != 0 && i > 0) begin
        w_lz[i] = v_run;
      end
    end
  end

  always_comb begin
    w_nib       = '0;
    w_sel_lz    = 1'b0;
    w_sel_blink = 1'b0;
    w_sel_dp    = 1'b0;
    w_an_nxt    = '1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (int'(r_idx) == i) begin
        w_nib       = r_dig_snap[4*i +: 4];
        w_sel_lz    = w_lz[i];
        w_sel_blink = blink_mask[i] & r_phase;
        w_sel_dp    = r_dp_snap[i];
        w_an_nxt[i] = 1'b0;
      end
    end
  end

  seg7_glyph u_glyph (
    .i_nibble   (w_nib),
    .i_hex_mode (HEX_BIT),
    .o_seg      (w_glyph)
  );

  // A leading-zero blank keeps its decimal point; a blinked-off digit loses it.
  always_comb begin
    w_drv_nxt.seg = SEG_BLANK;
    w_drv_nxt.dp  = 1'b1;
    if (enable) begin
      if (!(w_sel_lz || w_sel_blink)) begin
        w_drv_nxt.seg = w_glyph;
      end
      w_drv_nxt.dp = ~(w_sel_dp & ~w_sel_blink);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
      r_an  <= '1;
    end else begin
      r_seg <= w_drv_nxt.seg;
      r_dp  <= w_drv_nxt.dp;
      r_an  <= enable ? w_an_nxt : '1;
    end
  end

  assign seg_out    = r_seg;
  assign dp_out     = r_dp;
  assign an_out     = r_an;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a hex/LZ instance and a dash/no-LZ instance share stimulus.
`timescale 1ns/1ps
module tb_seg7_scan_driver;

  localparam int N  = 4;
  localparam int P  = 4;
  localparam int BF = 2;
  localparam int PN = N * P;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blink_mask = '0;

  logic [6:0]  seg_h, seg_d;
  logic        dp_h, dp_d;
  logic [3:0]  an_h, an_d;
  logic        fd_h, fd_d;

  seg7_scan_driver #(.N_DIGITS(N), .PRESCALE(P), .BLINK_FRAMES(BF), .HEX_MODE(1), .LZ_BLANK(1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .digits(digits), .dp_in(dp_in),
    .blink_mask(blink_mask), .seg_out(seg_h), .dp_out(dp_h), .an_out(an_h), .frame_done(fd_h)
  );

  seg7_scan_driver #(.N_DIGITS(N), .PRESCALE(P), .BLINK_FRAMES(BF), .HEX_MODE(0), .LZ_BLANK(0)) dut_plain (
    .clk(clk), .reset(reset), .enable(enable), .digits(digits), .dp_in(dp_in),
    .blink_mask(blink_mask), .seg_out(seg_d), .dp_out(dp_d), .an_out(an_d), .frame_done(fd_d)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg_h;
    logic       dp_h;
    logic [6:0] seg_d;
    logic       dp_d;
    logic [3:0] an;
    logic       fd;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_err = 0;
  int          m_c = 0;
  logic [15:0] m_dig = '0;
  logic [3:0]  m_dp = '0;

  function automatic logic [6:0] ref_glyph(input logic [3:0] v, input bit hex);
    if (!hex && v > 4'd9) return 7'b1111110;
    case (v)
      4'd0: return 7'b0000001;   4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;   4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;   4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;   4'd7: return 7'b0001101;
      4'd8: return 7'b0000000;   4'd9: return 7'b0000100;
      4'hA: return 7'b0001000;   4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;   4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;   default: return 7'b0111000;
    endcase
  endfunction

  // Output after edge c (1-based since reset release), derived from elapsed time alone.
  task automatic ref_out(input int c, input logic [15:0] snap, input logic [3:0] sdp,
                         input logic en, input logic [3:0] bm, input bit hex, input bit lz,
                         output logic [6:0] seg, output logic dp, output logic [3:0] an);
    int   idx, frames, msd;
    bit   ph, blink, shown;
    logic [3:0] nib;
    idx    = ((c - 1) / P) % N;
    frames = (c - 1) / PN;
    ph     = ((frames / BF) % 2) == 1;
    seg    = 7'h7F;
    dp     = 1'b1;
    an     = 4'hF;
    if (en) begin
      an[idx[1:0]] = 1'b0;
      msd = 0;
      for (int j = 0; j < N; j++) if (snap[4*j +: 4] != 4'h0) msd = j;
      nib   = snap[4*idx +: 4];
      blink = bm[idx[1:0]] && ph;
      shown = !lz || (idx <= msd);
      if (shown && !blink) seg = ref_glyph(nib, hex);
      dp = !(sdp[idx[1:0]] && !blink);
    end
  endtask

  task automatic push_expected();
    exp_t e;
    m_c++;
    ref_out(m_c, m_dig, m_dp, enable, blink_mask, 1'b1, 1'b1, e.seg_h, e.dp_h, e.an);
    ref_out(m_c, m_dig, m_dp, enable, blink_mask, 1'b0, 1'b0, e.seg_d, e.dp_d, e.an);
    e.fd = (m_c % PN) == 0;
    q.push_back(e);
    if (e.fd) begin
      m_dig = digits;
      m_dp  = dp_in;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("seg_hex", seg_h, e.seg_h);
      chk("dp_hex", dp_h, e.dp_h);
      chk("an_hex", an_h, e.an);
      chk("fd_hex", fd_h, e.fd);
      chk("seg_plain", seg_d, e.seg_d);
      chk("dp_plain", dp_d, e.dp_d);
      chk("an_plain", an_d, e.an);
      chk("fd_plain", fd_d, e.fd);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      push_expected();
      #1;
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_seg", seg_h, 7'h7F);
    chk("rst_dp", dp_h, 1);
    chk("rst_an", an_h, 4'hF);
    chk("rst_fd", fd_h, 0);
    chk("rst_an_plain", an_d, 4'hF);
    @(posedge clk);
    #1;
    chk("rst_hold_seg", seg_h, 7'h7F);
    chk("rst_hold_an", an_h, 4'hF);
    @(negedge clk);
    #2 reset = 1'b0;
    m_c   = 0;
    m_dig = '0;
    m_dp  = '0;
  endtask

  function automatic logic [15:0] rand_digits();
    logic [15:0] v;
    for (int k = 0; k < 4; k++)
      v[4*k +: 4] = ($urandom_range(2) == 0) ? 4'h0 : 4'($urandom_range(15));
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset_pulse();
    enable = 1'b1;
    digits = 16'h1234;
    step(3 * PN + 3);
    digits = 16'h0070;
    step(2 * PN);
    digits = 16'h0000;
    step(2 * PN);
    digits = 16'h00AB;
    dp_in  = 4'b0100;
    step(2 * PN);
    digits = 16'h1234;
    dp_in  = 4'b0000;
    step(PN + 6);
    digits = 16'h5678;
    step(2 * PN);
    blink_mask = 4'b0001;
    dp_in      = 4'b0001;
    step(8 * PN);
    enable = 1'b0;
    step(PN + 3);
    enable = 1'b1;
    step(PN);
    reset_pulse();
    step(2 * PN);
    for (int i = 0; i < 1200; i++) begin
      step(1);
      if ($urandom_range(7) == 0) digits = rand_digits();
      if ($urandom_range(15) == 0) dp_in = 4'($urandom_range(15));
      if ($urandom_range(31) == 0) blink_mask = 4'($urandom_range(15));
      enable = ($urandom_range(15) != 0);
      if (i == 600) reset_pulse();
    end
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
